// File: rtl/adder_pkg.sv
// Shared definitions for the skewed pipelined adder: the add/sub mode encoding
// and helpers that work out the stage count and the bit range of each chunk.
package adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int stage_count(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int chunk_lo(input int idx, input int chunk);
    return idx * chunk;
  endfunction

  // The last chunk is narrower when width is not a multiple of chunk.
  function automatic int chunk_width(input int width, input int chunk, input int idx);
    int lo;
    lo = idx * chunk;
    return ((width - lo) < chunk) ? (width - lo) : chunk;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: holds an in-flight beat and resolves one chunk of the sum,
// passing the carry on to the next stage. The ready path is combinational.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  input  logic             up_sub,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic [WIDTH-1:0] dn_sum,
  output logic             dn_carry,
  output logic             dn_cmsb,
  output logic             dn_sub
);

  logic             valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  mode_e            mode_reg;
  logic             load;
  logic             ripple_c;

  // A held beat leaves whenever downstream can take it, so ready is ~v | adv.
  assign up_ready = ~valid_reg | dn_ready;
  assign load     = up_valid & up_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      mode_reg  <= MODE_ADD;
    end else begin
      if (load) begin
        valid_reg <= 1'b1;
      end else if (dn_ready) begin
        valid_reg <= 1'b0;
      end
      // Data registers only move when a beat actually arrives.
      if (load) begin
        a_reg     <= up_a;
        b_reg     <= up_b;
        sum_reg   <= up_sum;
        carry_reg <= up_carry;
        mode_reg  <= mode_e'(up_sub);
      end
    end
  end

  always_comb begin
    dn_sum   = sum_reg;
    dn_cmsb  = 1'b0;
    dn_carry = 1'b0;
    ripple_c = carry_reg;
    for (int i = 0; i < CW; i++) begin
      // After the last iteration this holds the carry into the chunk's top bit.
      dn_cmsb        = ripple_c;
      dn_sum[LO + i] = a_reg[LO + i] ^ b_reg[LO + i] ^ ripple_c;
      ripple_c       = (a_reg[LO + i] & b_reg[LO + i]) |
                       (ripple_c & (a_reg[LO + i] ^ b_reg[LO + i]));
    end
    dn_carry = ripple_c;
  end

  assign dn_valid = valid_reg;
  assign dn_a     = a_reg;
  assign dn_b     = b_reg;
  assign dn_sub   = mode_reg;

endmodule

// File: rtl/skewed_pipelined_adder.sv
// WIDTH-bit add/subtract resolved CHUNK bits per stage with valid/ready flow control;
// the top maps stage 0 entry, the chain of chunk stages and the output register.
module skewed_pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  logic [WIDTH-1:0] a_pipe   [0:STAGES];
  logic [WIDTH-1:0] b_pipe   [0:STAGES];
  logic [WIDTH-1:0] sum_pipe [0:STAGES];
  logic [STAGES:0]  carry_pipe;
  logic [STAGES:0]  sub_pipe;
  logic [STAGES:0]  valid_pipe;
  logic [STAGES:0]  ready_pipe;
  logic [STAGES-1:0] cmsb_vec;

  logic             run_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             out_load;
  logic             unused_sink;

  // Holds off input acceptance until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  assign valid_pipe[0] = in_valid & run_reg;
  assign in_ready      = ready_pipe[0] & run_reg;
  assign a_pipe[0]     = a;
  assign b_pipe[0]     = (mode_e'(sub) == MODE_SUB) ? ~b : b;
  assign sum_pipe[0]   = '0;
  assign carry_pipe[0] = (mode_e'(sub) == MODE_SUB) ? 1'b1 : cin;
  assign sub_pipe[0]   = sub;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      adder_chunk_stage #(
        .WIDTH (WIDTH),
        .LO    (chunk_lo(gi, CHUNK)),
        .CW    (chunk_width(WIDTH, CHUNK, gi))
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (valid_pipe[gi]),
        .up_ready (ready_pipe[gi]),
        .up_a     (a_pipe[gi]),
        .up_b     (b_pipe[gi]),
        .up_sum   (sum_pipe[gi]),
        .up_carry (carry_pipe[gi]),
        .up_sub   (sub_pipe[gi]),
        .dn_valid (valid_pipe[gi+1]),
        .dn_ready (ready_pipe[gi+1]),
        .dn_a     (a_pipe[gi+1]),
        .dn_b     (b_pipe[gi+1]),
        .dn_sum   (sum_pipe[gi+1]),
        .dn_carry (carry_pipe[gi+1]),
        .dn_cmsb  (cmsb_vec[gi]),
        .dn_sub   (sub_pipe[gi+1])
      );
    end
  endgenerate

  // The output register is the final pipeline slot.
  assign ready_pipe[STAGES] = ~out_valid_reg | out_ready;
  assign out_load           = valid_pipe[STAGES] & ready_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      if (out_load) begin
        out_valid_reg <= 1'b1;
        s_reg         <= sum_pipe[STAGES];
        cout_reg      <= carry_pipe[STAGES];
        ovf_reg       <= cmsb_vec[STAGES-1] ^ carry_pipe[STAGES];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Fully consumed operands and intermediate MSB carries have no further use.
  assign unused_sink = ^{a_pipe[STAGES], b_pipe[STAGES], sub_pipe[STAGES], cmsb_vec};

  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_skewed_pipelined_adder.sv
// Bench for skewed_pipelined_adder: three configurations (32/8, 13/4, 4/1) share one
// stimulus stream; results are scored against an arithmetic reference model.
module tb_skewed_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready32, in_ready13, in_ready4;
  logic        out_valid32, out_valid13, out_valid4;
  logic [31:0] s32;
  logic [12:0] s13;
  logic [3:0]  s4;
  logic        cout32, cout13, cout4;
  logic        ovf32, ovf13, ovf4;

  int checks = 0;
  int failures = 0;
  int beat_no = 0;

  always #5 clk = ~clk;

  skewed_pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready), .s(s32), .cout(cout32), .ovf(ovf32)
  );

  skewed_pipelined_adder #(.WIDTH(13), .CHUNK(4)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready13),
    .a(a[12:0]), .b(b[12:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid13), .out_ready(out_ready), .s(s13), .cout(cout13), .ovf(ovf13)
  );

  skewed_pipelined_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [33:0] r32;
    logic [33:0] r13;
    logic [33:0] r4;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic stall_prev = 1'b0;
  logic [33:0] held32;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer add, carry from bit w, overflow from the signed range.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                           input logic c_in, input logic do_sub);
    longint mask, ua, ub, c, full, half, sa, sb, ssum;
    logic [31:0] yy;
    logic [63:0] sres;
    logic co, ov;
    mask = (longint'(1) <<< w) - 1;
    yy   = do_sub ? ~y : y;
    ua   = longint'({32'b0, x}) & mask;
    ub   = longint'({32'b0, yy}) & mask;
    c    = do_sub ? 1 : (c_in ? 1 : 0);
    full = ua + ub + c;
    sres = 64'(full & mask);
    co   = ((full >>> w) & 1) != 0;
    half = longint'(1) <<< (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    ssum = sa + sb + c;
    ov   = (ssum >= half) || (ssum < -half);
    return {ov, co, sres[31:0]};
  endfunction

  // Scoreboard: transfers are judged at the negedge preceding the capturing posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold32", {out_valid32, ovf32, cout32, s32}, {1'b1, held32});
      end
      if (out_valid32 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("orphan_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          beat_no++;
          $display("beat %0d a=%08h b=%08h cin=%0b sub=%0b s32=%08h c=%0b v=%0b s13=%04h s4=%01h",
                   beat_no, mon_e.a, mon_e.b, mon_e.cin, mon_e.sub, s32, cout32, ovf32, s13, s4);
          check("res32", {ovf32, cout32, s32}, mon_e.r32);
          check("res13", {out_valid13, ovf13, cout13, s13},
                {1'b1, mon_e.r13[33], mon_e.r13[32], mon_e.r13[12:0]});
          check("res4", {out_valid4, ovf4, cout4, s4},
                {1'b1, mon_e.r4[33], mon_e.r4[32], mon_e.r4[3:0]});
        end
      end
      stall_prev = out_valid32 && !out_ready;
      held32     = {ovf32, cout32, s32};
      if (in_valid && in_ready32) begin
        exp_q.push_back('{a: a, b: b, cin: cin, sub: sub,
                          r32: ref_add(32, a, b, cin, sub),
                          r13: ref_add(13, a, b, cin, sub),
                          r4:  ref_add(4, a, b, cin, sub)});
      end
    end
  end

  // Single beat with out_ready high: latency and result against the table entry.
  task automatic run_one(input vec_t v);
    int lat32 = 0, lat13 = 0, lat4 = 0;
    logic [33:0] got = '0;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready32) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (out_valid32 && lat32 == 0) begin
        lat32 = cyc;
        got   = {ovf32, cout32, s32};
      end
      if (out_valid13 && lat13 == 0) lat13 = cyc;
      if (out_valid4 && lat4 == 0) lat4 = cyc;
      if (lat32 != 0 && lat13 != 0 && lat4 != 0) break;
    end
    check("latency32", 64'(lat32), 64'd4);
    check("latency13", 64'(lat13), 64'd4);
    check("latency4", 64'(lat4), 64'd4);
    check("table_result", 64'(got), 64'({v.ovf, v.cout, v.s}));
  endtask

  task automatic set_operands(input int idx, input bit exhaustive);
    logic [31:0] ra, rb;
    logic [31:0] ui;
    ra = $urandom();
    rb = $urandom();
    ui = 32'(idx);
    if (exhaustive) begin
      a   = {ra[31:4], ui[3:0]};
      b   = {rb[31:4], ui[7:4]};
      cin = (ui[9:8] == 2'd1);
      sub = (ui[9:8] == 2'd2);
    end else begin
      a   = ra;
      b   = rb;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic stream(input int n, input bit exhaustive);
    int sent = 0;
    int cyc = 0;
    bit xfer;
    set_operands(0, exhaustive);
    in_valid = 1'b1;
    while (sent < n && cyc < 20000) begin
      out_ready = exhaustive ? ($urandom_range(0, 3) != 0) : ((cyc % 10) < 7);
      @(negedge clk);
      xfer = in_valid && in_ready32;
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        sent++;
        if (sent < n) set_operands(sent, exhaustive);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream_sent", 64'(sent), 64'(n));
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("stream_drained", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs[0] = '{a: 32'h0000_00FF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, s: 32'h0000_0100, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, sub: 1'b0, s: 32'h0000_0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, s: 32'h8000_0000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 32'h0000_0005, b: 32'h0000_0007, cin: 1'b0, sub: 1'b1, s: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 32'h8000_0000, b: 32'h0000_0001, cin: 1'b0, sub: 1'b1, s: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 32'h0000_0007, b: 32'h0000_0005, cin: 1'b1, sub: 1'b1, s: 32'h0000_0002, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, sub: 1'b0, s: 32'h0000_0000, cout: 1'b1, ovf: 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid32, out_valid13, out_valid4, ovf32, cout32, s32},
          {3'b000, 2'b00, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {in_ready32, in_ready13, in_ready4}, 3'b111);

    // Directed table.
    for (int i = 0; i < 7; i++) run_one(vecs[i]);

    // Random stream with periodic back-pressure.
    stream(100, 1'b0);

    // Reset with three beats in flight and the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = $urandom(); b = $urandom(); cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid32) break;
      @(posedge clk); #1;
    end
    check("inflight_before_reset", 64'(out_valid32), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", {out_valid32, out_valid13, out_valid4, s32}, {3'b000, 32'h0});
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid32 || out_valid13 || out_valid4) seen = 1'b1;
    end
    check("no_stale_after_reset", 64'(seen), 64'd0);
    run_one(vecs[0]);

    // Exhaustive 4-bit add, add with carry and subtract.
    stream(768, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
